apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB master bridging a CPU strobe interface
//               to four memory-mapped APB slaves (4 KB windows at 0x1000_0000).
//               Optional ACCESS-phase timeout when APB_MASTER_TIMEOUT_EN is
//               defined; without it ACCESS waits for PREADY indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int NUM_SLV        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    // The port list is hard-wired for four slaves; reject other builds early.
    if (NUM_SLV != 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master: NUM_SLV must be 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               mapped;
    logic [1:0]         slv_idx;
    logic               unmapped_pulse;
    logic               in_access;
    logic               sel_pready;
    logic [31:0]        sel_prdata;
    logic               done_ok;
    logic               timeout_hit;
    logic [NUM_SLV-1:0] pready_vec;
    logic [NUM_SLV-1:0] psel_vec;
    logic [31:0]        prdata_arr [NUM_SLV];

    assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};
    assign prdata_arr[0] = PRDATA0;
    assign prdata_arr[1] = PRDATA1;
    assign prdata_arr[2] = PRDATA2;
    assign prdata_arr[3] = PRDATA3;

    // Windows 0x10000..0x10003 of addr[31:12] share addr[31:14] = 0x04000.
    assign mapped     = (addr[31:14] == 18'h04000);
    assign in_access  = (state == S_ACCESS);
    assign sel_pready = pready_vec[slv_idx];
    assign sel_prdata = prdata_arr[slv_idx];
    assign done_ok    = in_access && sel_pready;

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a request is only taken in IDLE and not while an
    // unmapped-address error pulse is being returned.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (transfer && !unmapped_pulse) begin
                    accept = 1'b1;
                    if (mapped) begin
                        state_nx = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                if (done_ok || timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request capture: bus fields hold from SETUP through the last ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR          <= 32'd0;
            PWDATA         <= 32'd0;
            PWRITE         <= 1'b0;
            slv_idx        <= 2'd0;
            unmapped_pulse <= 1'b0;
        end else begin
            unmapped_pulse <= accept && !mapped;
            if (accept) begin
                PADDR   <= addr;
                PWDATA  <= wdata;
                PWRITE  <= write;
                slv_idx <= addr[13:12];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] access_cnt;

    // Counts ACCESS cycles; cleared in SETUP so each transfer starts at zero.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            access_cnt <= '0;
        end else if (state == S_SETUP) begin
            access_cnt <= '0;
        end else if (in_access) begin
            access_cnt <= access_cnt + 1'b1;
        end
    end

    // Fires in the last permitted ACCESS cycle if the slave is still stalling.
    assign timeout_hit = in_access && !sel_pready &&
                         (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // One select per slave, only outside IDLE.
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_psel
        assign psel_vec[i] = (state != S_IDLE) && (slv_idx == 2'(i));
    end

    assign PSEL0   = psel_vec[0];
    assign PSEL1   = psel_vec[1];
    assign PSEL2   = psel_vec[2];
    assign PSEL3   = psel_vec[3];
    assign PENABLE = in_access;

    // CPU response: combinational from the selected slave, zero otherwise.
    always_comb begin
        ready = done_ok || timeout_hit || unmapped_pulse;
        err   = timeout_hit || unmapped_pulse;
        rdata = (done_ok && !PWRITE) ? sel_prdata : 32'd0;
    end

endmodule
`default_nettype wire
